writeback_regfile: RTL and testbench

Writeback stage plus architectural integer register file for the 5-stage RV32I pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to x1–x31 on the clock edge. It also serves the two combinational read ports used by decode and exports the current writeback value for EX-stage forwarding.

---
 rtl/riscv_wb_pkg.sv | 17 +
 rtl/writeback_mux.sv | 34 +++
 rtl/writeback_regfile.sv | 74 +++++++
 tb/tb_writeback_regfile.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
// Shared constants for the RV32I writeback stage and register file.
package riscv_wb_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [1:0] {
    REGSRC_ALU_MEM = 2'b00,
    REGSRC_LINK    = 2'b01,
    REGSRC_LUI     = 2'b10,
    REGSRC_AUIPC   = 2'b11
  } regsrc_e;

  localparam int WB_REGWRITE_BIT = 3;
  localparam int WB_MEMTOREG_BIT = 2;

endpackage

// File: rtl/writeback_mux.sv
// Writeback value select: ALU/load, link (PC+4), LUI and AUIPC (PC+imm).
module writeback_mux
  import riscv_wb_pkg::*;
#(
  parameter int XLEN = riscv_wb_pkg::XLEN
) (
  input  logic [1:0]      regsrc_i,
  input  logic            memtoreg_i,
  input  logic [XLEN-1:0] read_data_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] u_imm_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] wdata_o
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;

  // Carries out of the top bit are dropped: addresses wrap silently.
  assign pc_plus4    = pc_i + XLEN'(4);
  assign pc_plus_imm = pc_i + u_imm_i;

  always_comb begin
    wdata_o = '0;
    case (regsrc_i)
      REGSRC_ALU_MEM: wdata_o = memtoreg_i ? read_data_i : alu_result_i;
      REGSRC_LINK:    wdata_o = pc_plus4;
      REGSRC_LUI:     wdata_o = u_imm_i;
      REGSRC_AUIPC:   wdata_o = pc_plus_imm;
      default:        wdata_o = '0;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus x1-x31 register file with two combinational read ports.
// Define REGFILE_BYPASS_EN for write-first reads; default build is read-first.
module writeback_regfile
  import riscv_wb_pkg::*;
#(
  parameter int XLEN  = riscv_wb_pkg::XLEN,
  parameter int NREGS = riscv_wb_pkg::NREGS
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      WB_control,
  input  logic [4:0]      RegDst,
  input  logic [XLEN-1:0] ReadData,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] U_type_immediate,
  input  logic [XLEN-1:0] PC,
  input  logic [4:0]      ReadReg1,
  input  logic [4:0]      ReadReg2,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            WB_RegWrite,
  output logic [4:0]      WB_RegDst,
  output logic [XLEN-1:0] WB_WriteData
);

  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic            unused_wb_ctrl;

  assign unused_wb_ctrl = WB_control[4];

  writeback_mux #(.XLEN(XLEN)) u_wb_mux (
    .regsrc_i     (WB_control[1:0]),
    .memtoreg_i   (WB_control[WB_MEMTOREG_BIT]),
    .read_data_i  (ReadData),
    .alu_result_i (ALUResult),
    .u_imm_i      (U_type_immediate),
    .pc_i         (PC),
    .wdata_o      (WB_WriteData)
  );

  assign WB_RegWrite = WB_control[WB_REGWRITE_BIT] && (RegDst != '0);
  assign WB_RegDst   = RegDst;

  // x0 has no storage; each remaining register clears asynchronously.
  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
        regs_q[g] <= '0;
      else if (WB_RegWrite && (RegDst == 5'(g)))
        regs_q[g] <= WB_WriteData;
    end
  end

  always_comb begin
    ReadData1 = '0;
    if ((ReadReg1 != '0) && (int'(ReadReg1) < NREGS))
      ReadData1 = regs_q[ReadReg1];
`ifdef REGFILE_BYPASS_EN
    if (RESET && WB_RegWrite && (ReadReg1 == RegDst))
      ReadData1 = WB_WriteData;
`endif
  end

  always_comb begin
    ReadData2 = '0;
    if ((ReadReg2 != '0) && (int'(ReadReg2) < NREGS))
      ReadData2 = regs_q[ReadReg2];
`ifdef REGFILE_BYPASS_EN
    if (RESET && WB_RegWrite && (ReadReg2 == RegDst))
      ReadData2 = WB_WriteData;
`endif
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed plus randomized checks of writeback_regfile against a simple array model.
`timescale 1ns/10ps
module tb_writeback_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  WB_control, RegDst, ReadReg1, ReadReg2;
  logic [31:0] ReadData, ALUResult, U_type_immediate, PC;
  logic [31:0] ReadData1, ReadData2, WB_WriteData;
  logic        WB_RegWrite;
  logic [4:0]  WB_RegDst;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [32];

  writeback_regfile dut (
    .CLK(CLK), .RESET(RESET), .WB_control(WB_control), .RegDst(RegDst),
    .ReadData(ReadData), .ALUResult(ALUResult), .U_type_immediate(U_type_immediate),
    .PC(PC), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .WB_RegWrite(WB_RegWrite), .WB_RegDst(WB_RegDst),
    .WB_WriteData(WB_WriteData)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_wb(input logic mtr, input logic [1:0] src,
      input logic [31:0] rd, alu, u, pc);
    case (src)
      2'd0:    return mtr ? rd : alu;
      2'd1:    return pc + 32'd4;
      2'd2:    return u;
      default: return pc + u;
    endcase
  endfunction

  // One clock: drive at negedge, check combinational outputs, then check post-edge reads.
  task automatic step(input logic we, mtr, input logic [1:0] src, input logic [4:0] dst,
      input logic [31:0] rd, alu, u, pc, input logic [4:0] r1, r2);
    logic        e_we;
    logic [31:0] e_wd, e1, e2;
    @(negedge CLK);
    WB_control = {1'($urandom), we, mtr, src};
    RegDst = dst; ReadData = rd; ALUResult = alu; U_type_immediate = u; PC = pc;
    ReadReg1 = r1; ReadReg2 = r2;
    #1;
    e_we = we && (dst != 0);
    e_wd = ref_wb(mtr, src, rd, alu, u, pc);
    e1 = (r1 == 0) ? 32'd0 : (BYP && e_we && r1 == dst) ? e_wd : model[r1];
    e2 = (r2 == 0) ? 32'd0 : (BYP && e_we && r2 == dst) ? e_wd : model[r2];
    chk("wb_regwrite", {31'd0, WB_RegWrite}, {31'd0, e_we});
    chk("wb_regdst", {27'd0, WB_RegDst}, {27'd0, dst});
    chk("wb_writedata", WB_WriteData, e_wd);
    chk("rd1_pre", ReadData1, e1);
    chk("rd2_pre", ReadData2, e2);
    @(posedge CLK);
    if (e_we) model[dst] = e_wd;
    #1;
    chk("rd1_post", ReadData1, (r1 == 0) ? 32'd0 : model[r1]);
    chk("rd2_post", ReadData2, (r2 == 0) ? 32'd0 : model[r2]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    RESET = 1'b0; WB_control = '0; RegDst = '0; ReadData = '0; ALUResult = '0;
    U_type_immediate = '0; PC = '0; ReadReg1 = '0; ReadReg2 = '0;
    #2;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #0.05;
      chk("reset_rd1", ReadData1, 32'd0);
      chk("reset_rd2", ReadData2, 32'd0);
    end

    // Write presented while reset is held must be dropped.
    WB_control = 5'b01000; RegDst = 5'd5; ALUResult = 32'hDEADBEEF;
    @(posedge CLK);
    @(negedge CLK);
    WB_control = '0; RESET = 1'b1; ReadReg1 = 5'd5;
    #1;
    chk("write_in_reset_x5", ReadData1, 32'd0);

    step(1, 0, 2'd0, 5'd3, 32'h0, 32'h12345678, 32'h0, 32'h0, 5'd3, 5'd0);
    chk("alu_x3", ReadData1, 32'h12345678);
    step(1, 1, 2'd0, 5'd3, 32'hCAFEF00D, 32'h12345678, 32'h0, 32'h0, 5'd3, 5'd3);
    chk("mem_x3", ReadData2, 32'hCAFEF00D);
    step(1, 1, 2'd1, 5'd4, 32'h5555, 32'h6666, 32'h0, 32'hFFFFFFFC, 5'd4, 5'd3);
    chk("link_wrap", ReadData1, 32'h0);
    step(1, 0, 2'd2, 5'd6, 32'h0, 32'h1, 32'hABCDE000, 32'h40, 5'd6, 5'd4);
    chk("lui", ReadData1, 32'hABCDE000);
    step(1, 0, 2'd3, 5'd8, 32'h0, 32'h1, 32'h2000, 32'h1000, 5'd8, 5'd6);
    chk("auipc", ReadData1, 32'h3000);
    step(1, 0, 2'd0, 5'd0, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0);
    chk("x0_read", ReadData1, 32'h0);
    step(1, 0, 2'd0, 5'd7, 32'h0, 32'h11, 32'h0, 32'h0, 5'd1, 5'd2);
    step(1, 0, 2'd0, 5'd7, 32'h0, 32'h22, 32'h0, 32'h0, 5'd7, 5'd7);
    chk("rw_same_x7", ReadData1, 32'h22);

    for (int n = 0; n < 300; n++)
      step(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom & 32'hFFFFF000, $urandom, 5'($urandom), 5'($urandom));

    for (int i = 1; i < 32; i++)
      step(1, 0, 2'd0, 5'(i), 32'h0, 32'(i), 32'h0, 32'h0, 5'(i), 5'(i - 1));

    // Asynchronous reset between edges clears everything before the next edge.
    @(negedge CLK);
    WB_control = '0;
    #1 RESET = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i);
      #0.05;
      chk("midrun_rst_rd1", ReadData1, 32'd0);
      chk("midrun_rst_rd2", ReadData2, 32'd0);
    end
    for (int i = 0; i < 32; i++) model[i] = '0;
    WB_control = 5'b01000; RegDst = 5'd9; ALUResult = 32'h99;
    @(posedge CLK);
    @(negedge CLK);
    WB_control = '0; RESET = 1'b1; ReadReg1 = 5'd9;
    #1;
    chk("blocked_write_x9", ReadData1, 32'd0);

    for (int n = 0; n < 60; n++)
      step(1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom,
           $urandom & 32'hFFFFF000, $urandom, 5'($urandom), 5'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
